// File: rtl/apb_gpio_ctrl.sv
// apb_gpio_ctrl: APB3 register block in front of one GPIO pad wrapper port.
// Holds the output-data and direction registers and synchronises the pad
// read value. It also raises a per-pin maskable edge/level interrupt.
//
// Ports:
//   PCLK, PRESETn        APB clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB control
//   PADDR[11:0]          byte address; [4:2] select a register, [11:5] must be 0
//   PWDATA[31:0]         write data
//   PRDATA[31:0]         combinational read data
//   PREADY, PSLVERR      tied 1 / 0 (zero wait states, never errors)
//   DIR, WDATA           per-pin direction / output value to the pad wrapper
//   RDATA                pad read value, asynchronous to PCLK
//   IRQ                  level interrupt, OR of pending status flags
module apb_gpio_ctrl #(
    parameter int unsigned GPIO_WIDTH = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [11:0]           PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [GPIO_WIDTH-1:0] DIR,
    output logic [GPIO_WIDTH-1:0] WDATA,
    input  logic [GPIO_WIDTH-1:0] RDATA,
    output logic                  IRQ
);

    localparam int unsigned W      = GPIO_WIDTH;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] OFS_DATA_OUT   = 3'd0;
    localparam logic [2:0] OFS_DIR        = 3'd1;
    localparam logic [2:0] OFS_DATA_IN    = 3'd2;
    localparam logic [2:0] OFS_INT_EN     = 3'd3;
    localparam logic [2:0] OFS_INT_TYPE   = 3'd4;
    localparam logic [2:0] OFS_INT_POL    = 3'd5;
    localparam logic [2:0] OFS_INT_STATUS = 3'd6;
    localparam logic [2:0] OFS_DATA_TGL   = 3'd7;

    logic [W-1:0] data_out_q;
    logic [W-1:0] dir_q;
    logic [W-1:0] int_en_q;
    logic [W-1:0] int_type_q;
    logic [W-1:0] int_pol_q;
    logic [W-1:0] int_status_q;
    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;
    logic [W-1:0] sync3_q;

    logic         addr_hit;
    logic [2:0]   ofs;
    logic         wr_stb;
    logic [W-1:0] wr_data;
    logic         we_data_out;
    logic         we_dir;
    logic         we_int_en;
    logic         we_int_type;
    logic         we_int_pol;
    logic         we_int_status;
    logic         we_data_tgl;
    logic [W-1:0] clr;
    logic [W-1:0] edge_ev;
    logic [W-1:0] level_ev;
    logic [W-1:0] pin_ev;
    logic [W-1:0] rd_val;
    logic         unused_ok;

    // Address decode and write strobes
    assign addr_hit      = (PADDR[11:5] == 7'd0);
    assign ofs           = PADDR[4:2];
    assign wr_stb        = PSEL & PENABLE & PWRITE & addr_hit;
    assign wr_data       = PWDATA[W-1:0];
    assign we_data_out   = wr_stb && (ofs == OFS_DATA_OUT);
    assign we_dir        = wr_stb && (ofs == OFS_DIR);
    assign we_int_en     = wr_stb && (ofs == OFS_INT_EN);
    assign we_int_type   = wr_stb && (ofs == OFS_INT_TYPE);
    assign we_int_pol    = wr_stb && (ofs == OFS_INT_POL);
    assign we_int_status = wr_stb && (ofs == OFS_INT_STATUS);
    assign we_data_tgl   = wr_stb && (ofs == OFS_DATA_TGL);
    assign clr           = we_int_status ? wr_data : '0;

    // Address bits [1:0] and PWDATA bits above the port width carry no meaning
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    // Output data register; toggle writes flip bits written as 1
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out_q <= '0;
        end else if (we_data_out) begin
            data_out_q <= wr_data;
        end else if (we_data_tgl) begin
            data_out_q <= data_out_q ^ wr_data;
        end
    end

    // Plain RW configuration registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dir_q      <= '0;
            int_en_q   <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
        end else begin
            if (we_dir)      dir_q      <= wr_data;
            if (we_int_en)   int_en_q   <= wr_data;
            if (we_int_type) int_type_q <= wr_data;
            if (we_int_pol)  int_pol_q  <= wr_data;
        end
    end

    // Pad input synchroniser; third stage exists only for edge detection
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= RDATA;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Per-pin event selection by type and polarity
    assign edge_ev  = (int_pol_q & sync2_q & ~sync3_q) | (~int_pol_q & ~sync2_q & sync3_q);
    assign level_ev = ~(sync2_q ^ int_pol_q);
    assign pin_ev   = (int_type_q & edge_ev) | (~int_type_q & level_ev);

    // Pending flags: a new event wins over a simultaneous W1C
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            int_status_q <= '0;
        end else begin
            int_status_q <= (int_status_q & ~clr) | (pin_ev & int_en_q);
        end
    end

    // Read mux
    always_comb begin
        rd_val = '0;
        case (ofs)
            OFS_DATA_OUT:   rd_val = data_out_q;
            OFS_DIR:        rd_val = dir_q;
            OFS_DATA_IN:    rd_val = sync2_q;
            OFS_INT_EN:     rd_val = int_en_q;
            OFS_INT_TYPE:   rd_val = int_type_q;
            OFS_INT_POL:    rd_val = int_pol_q;
            OFS_INT_STATUS: rd_val = int_status_q;
            default:        rd_val = '0;
        endcase
    end

    assign PRDATA  = (PSEL & ~PWRITE & addr_hit) ? DATA_W'(rd_val) : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign DIR     = dir_q;
    assign WDATA   = data_out_q;
    assign IRQ     = |int_status_q;

endmodule

// File: doc/apb_gpio_ctrl.md
Name: apb_gpio_ctrl

Overview:
APB3 slave register block that sits directly upstream of the GPIO pad wrapper. It holds the output-data and direction registers, which drive the wrapper's WDATA and DIR. It synchronises the wrapper's RDATA for software reads and generates a per-pin maskable edge/level interrupt. One instance serves one GPIO port of GPIO_WIDTH pins.

Parameters:
GPIO_WIDTH, 16, number of pins; legal range 1..32.

Ports:
PCLK  input  1  APB clock; all state is clocked on the rising edge.
PRESETn  input  1  asynchronous, active-low reset.
PSEL  input  1  APB select.
PENABLE  input  1  APB access phase.
PWRITE  input  1  1 = write, 0 = read.
PADDR  input  12  byte address; only [4:2] are decoded, [11:5] must be 0 for a hit.
PWDATA  input  32  write data.
PRDATA  output  32  read data.
PREADY  output  1  tied 1 (zero wait states).
PSLVERR  output  1  tied 0.
DIR  output  GPIO_WIDTH  per-pin direction to pad wrapper; 1 = drive.
WDATA  output  GPIO_WIDTH  per-pin output value to pad wrapper.
RDATA  input  GPIO_WIDTH  pad-wrapper read value; asynchronous to PCLK; reads 0 on pins with DIR=1.
IRQ  output  1  level interrupt, active high.

Behaviour:
- Reset: asynchronous on PRESETn low. All registers, sync flops, INT_STATUS and IRQ clear to 0 immediately. DIR=0 (all inputs) and WDATA=0. Reset mid-transfer aborts the transfer with no register update.
- Write strobe: PSEL & PENABLE & PWRITE. The target register updates on that PCLK edge. Only bits [GPIO_WIDTH-1:0] are stored; upper PWDATA bits are ignored.
- Read: PRDATA = decoded register value when PSEL & ~PWRITE, else 0. Decode is combinational from registers. Bits above GPIO_WIDTH read 0.
- Register map (offset, access, function):
  0x00 DATA_OUT, RW, drives WDATA directly.
  0x04 DIR, RW, drives DIR directly.
  0x08 DATA_IN, RO, second sync stage of RDATA.
  0x0C INT_EN, RW, per-pin interrupt enable.
  0x10 INT_TYPE, RW, 1 = edge, 0 = level.
  0x14 INT_POL, RW, 1 = rising/high, 0 = falling/low.
  0x18 INT_STATUS, R/W1C, pending flags.
  0x1C DATA_TGL, WO, write-1 toggles the DATA_OUT bit; reads 0.
- Unmapped offsets: read 0; writes ignored; no error.
- Synchroniser: sync1 <= RDATA, sync2 <= sync1, sync3 <= sync2, per bit.
  - DATA_IN = sync2, so a pad change is visible after 2 PCLK edges.
- Event per pin i:
  - edge mode: pol ? (sync2 & ~sync3) : (~sync2 & sync3)
  - level mode: sync2 == pol
- INT_STATUS[i] next value = (INT_STATUS[i] & ~clr[i]) | (event[i] & INT_EN[i]), where clr = W1C write data.
  - Set wins over a simultaneous clear.
  - Level mode: the bit re-sets every cycle while the condition holds, so a clear takes effect only once the condition is gone.
  - Clearing INT_EN does not clear pending status.
- IRQ = OR of INT_STATUS, a combinational OR of flops with no extra register.
  - Edge-interrupt latency: pad edge to IRQ high is 3 PCLK edges.
- Event detection ignores DIR. A pin switched to output reads 0 at the pad, which can raise a falling-edge event; software masks it via INT_EN.
- DATA_TGL and a DATA_OUT write never coincide (single APB port).

Test Plan:
- Reset: assert PRESETn=0 mid-write to DATA_OUT -> DIR=0, WDATA=0, IRQ=0 immediately; after release, all registers read 0.
- Register R/W: write 0xFFFFA5A5 to 0x00 and 0x5A5A to 0x04 -> WDATA=0xA5A5, DIR=0x5A5A; readback 0x0000A5A5 / 0x00005A5A. Write 0x000F to 0x1C -> WDATA=0xA5AA. Read 0x20 -> 0.
- Input sync: RDATA changes 0x0000->0x1234 -> DATA_IN reads 0x0000 after 1 edge and 0x1234 after 2 edges.
- Rising-edge irq: INT_EN=0x0001, INT_TYPE=0x0001, INT_POL=0x0001; RDATA[0] 0->1 -> INT_STATUS=0x0001 and IRQ=1 on the 3rd edge. Write 0x0001 to 0x18 -> IRQ=0 next edge. A falling edge does not set status.
- Level irq with clear collision: INT_TYPE=0, INT_POL=0x0002, INT_EN=0x0002, RDATA[1]=1 held -> status stays 1 despite W1C. Drop RDATA[1], then W1C -> status 0.
- Set/clear same cycle: edge event arrives on the same edge as a W1C of that bit -> bit remains 1, IRQ stays high.
